// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer: state encoding,
// stage-register control bundle and the bubble control-field constant.
package pipe_ctrl_pkg;

    localparam int STATE_W = 2;
    localparam int REG_W   = 5;
    localparam int CTRL_W  = 12;

    typedef enum logic [STATE_W-1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    // Control fields of a stage register holding a bubble are all zero.
    localparam logic [CTRL_W-1:0] BUBBLE_CTRL = '0;

    typedef struct packed {
        logic pc_we;
        logic if_id_we;
        logic id_ex_we;
        logic ex_mem_we;
        logic if_id_flush;
        logic id_ex_flush;
    } stage_ctl_t;

    localparam stage_ctl_t CTL_RESET    = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    localparam stage_ctl_t CTL_FREEZE   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam stage_ctl_t CTL_REDIRECT = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    localparam stage_ctl_t CTL_LOADUSE  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    localparam stage_ctl_t CTL_ADVANCE  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EX/MEM hazard inputs toward the sequencer and
// the stage-register enables, flushes and status back to the pipeline.
interface pipe_hazard_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic [REG_W-1:0]   id_rs1;
    logic [REG_W-1:0]   id_rs2;
    logic               id_use_rs1;
    logic               id_use_rs2;
    logic [REG_W-1:0]   ex_rd;
    logic               ex_mem_read;
    logic               ex_redirect;
    logic               dmem_busy;

    logic               pc_we;
    logic               if_id_we;
    logic               id_ex_we;
    logic               ex_mem_we;
    logic               if_id_flush;
    logic               id_ex_flush;
    logic               err_timeout;
    logic [STATE_W-1:0] state_o;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               ex_redirect, dmem_busy,
        input  pc_we, if_id_we, id_ex_we, ex_mem_we, if_id_flush, id_ex_flush,
               err_timeout, state_o
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               ex_redirect, dmem_busy,
        output pc_we, if_id_we, id_ex_we, ex_mem_we, if_id_flush, id_ex_flush,
               err_timeout, state_o
    );

endinterface

// File: rtl/pipe_hazard_cmp.sv
// Combinational load-use comparator: a source read in ID matches a non-x0
// destination of a valid producer in EX. Also used by the forwarding unit.
module pipe_hazard_cmp
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] i_rs1,
    input  logic [REG_W-1:0] i_rs2,
    input  logic             i_use_rs1,
    input  logic             i_use_rs2,
    input  logic [REG_W-1:0] i_rd,
    input  logic             i_rd_valid,
    output logic             o_hazard
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit = i_use_rs1 && (i_rs1 == i_rd);
    assign w_rs2_hit = i_use_rs2 && (i_rs2 == i_rd);
    assign o_hazard  = i_rd_valid && (i_rd != '0) && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline with dmem watchdog.
// Optional PIPE_HAZARD_CTRL_PERF_EN adds stall/flush performance counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 64
)
(
    input  logic              clk,
    input  logic              reset,
    pipe_hazard_ctrl_if.slave hz
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_flush_cnt
`endif
);

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t     r_state;
    logic [7:0] r_wait_cnt;
    logic       r_err;

    state_t     w_nxt;
    stage_ctl_t w_ctl;
    stage_ctl_t w_out;
    logic       w_load_use;

    pipe_hazard_cmp u_cmp (
        .i_rs1      (hz.id_rs1),
        .i_rs2      (hz.id_rs2),
        .i_use_rs1  (hz.id_use_rs1),
        .i_use_rs2  (hz.id_use_rs2),
        .i_rd       (hz.ex_rd),
        .i_rd_valid (hz.ex_mem_read),
        .o_hazard   (w_load_use)
    );

    // Priority: memory freeze, then redirect, then load-use (masked right after a bubble).
    always_comb begin
        w_nxt = ST_RUN;
        w_ctl = CTL_ADVANCE;
        if (hz.dmem_busy) begin
            w_nxt = ST_MEM_WAIT;
            w_ctl = CTL_FREEZE;
        end else if (hz.ex_redirect) begin
            w_nxt = ST_RUN;
            w_ctl = CTL_REDIRECT;
        end else if (w_load_use && (r_state != ST_LU_STALL)) begin
            w_nxt = ST_LU_STALL;
            w_ctl = CTL_LOADUSE;
        end
    end

    assign w_out = reset ? CTL_RESET : w_ctl;

    assign hz.pc_we       = w_out.pc_we;
    assign hz.if_id_we    = w_out.if_id_we;
    assign hz.id_ex_we    = w_out.id_ex_we;
    assign hz.ex_mem_we   = w_out.ex_mem_we;
    assign hz.if_id_flush = w_out.if_id_flush;
    assign hz.id_ex_flush = w_out.id_ex_flush;
    assign hz.state_o     = reset ? ST_RUN : r_state;
    assign hz.err_timeout = r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_nxt;
            // Counts consecutive frozen cycles; saturates so a long hang never re-arms.
            if (hz.dmem_busy) begin
                if (r_wait_cnt != 8'hFF) begin
                    r_wait_cnt <= r_wait_cnt + 8'd1;
                end
            end else begin
                r_wait_cnt <= '0;
            end
            if (hz.dmem_busy && (r_wait_cnt == WAIT_LAST)) begin
                r_err <= 1'b1;
            end
        end
    end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
        end else begin
            if (!w_ctl.pc_we) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (w_ctl.id_ex_flush) begin
                r_perf_flush <= r_perf_flush + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = r_perf_stall;
    assign perf_flush_cnt = r_perf_flush;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Stall/flush sequencer for the 5-stage RV32 pipeline. It sits beside the IF/ID, ID/EX and EX/MEM stage registers and drives their write-enable and flush inputs, plus the PC write enable. It resolves three hazard classes in fixed priority: data-memory busy, control redirect from EX, and load-use. It also flags data-memory hangs with a watchdog.

## Interface
- MAX_WAIT, default 64: number of consecutive MEM_WAIT cycles after which `err_timeout` asserts. Range 2..255.
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1 each  the ID instruction actually reads that source.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_mem_read  in  1  the EX instruction is a load.
- ex_redirect  in  1  the branch/jump in EX is taken; the PC takes a non-sequential target.
- dmem_busy  in  1  data memory cannot complete the MEM-stage access this cycle.
- pc_we, if_id_we, id_ex_we, ex_mem_we  out  1 each  stage-register write enables.
- if_id_flush, id_ex_flush  out  1 each  load a bubble (all control fields zero) into that register.
- err_timeout  out  1  sticky watchdog flag.
- state_o  out  2  current state, for debug.

## Operation
- States:
  - RUN = 0: normal issue.
  - LU_STALL = 1: cycle after a load-use bubble.
  - MEM_WAIT = 2: pipeline frozen on dmem_busy.
- Load-use is detected when `ex_mem_read` is high, `ex_rd` ≠ 0, and the ID instruction uses a source equal to `ex_rd` (`id_rs1` with `id_use_rs1`, or `id_rs2` with `id_use_rs2`).
- Outputs are Mealy: a function of state and current inputs. Rules are evaluated in priority order.
  1. `dmem_busy`=1 (any state): all four `_we`=0, both flushes=0. Next state is MEM_WAIT.
  2. `ex_redirect`=1: all `_we`=1, `if_id_flush`=1, `id_ex_flush`=1. Next state is RUN.
  3. Load-use, only when state ≠ LU_STALL: `pc_we`=0, `if_id_we`=0, `id_ex_we`=1, `ex_mem_we`=1, `id_ex_flush`=1. Next state is LU_STALL.
  4. Otherwise: all `_we`=1, flushes=0. Next state is RUN.
- In LU_STALL, load-use detection is masked. This guarantees forward progress because the bubble occupies EX.
- In MEM_WAIT with `dmem_busy`=0, rules 2–4 apply in the same cycle, so there is no extra dead cycle. Because EX was frozen, a redirect or load-use held in EX is acted on at exit.
- Watchdog: an 8-bit `wait_cnt` increments each cycle spent in MEM_WAIT and clears on leaving it. `err_timeout` sets when `wait_cnt` = MAX_WAIT−1 and `dmem_busy`=1. It stays set until reset. `wait_cnt` saturates and does not wrap.
- Reset: state=RUN, `wait_cnt`=0, `err_timeout`=0. While `reset`=1, outputs are forced to `pc_we`=0, `if_id_we`=1, `id_ex_we`=1, `ex_mem_we`=1, `if_id_flush`=1, `id_ex_flush`=1, `state_o`=0. A reset mid-stall or mid-wait abandons that sequence.

## Timing
- Zero-cycle combinational path from the hazard inputs to the enables and flushes. State and counter are registered.
- Load-use: the load is in EX in cycle t. Edge t+1 places a bubble in EX, keeps the ID instruction and keeps the PC. Cycle t+1 is LU_STALL. At edge t+2 the dependent instruction enters EX. Penalty is 1 cycle.
- Redirect in cycle t: at edge t+1, IF/ID and ID/EX hold bubbles and the PC holds the target. Penalty is 2 cycles.
- `dmem_busy` high for N cycles gives N frozen cycles, and the pipeline advances on the first cycle busy is low.
- Busy and redirect together: freeze takes priority, and the redirect is taken on the exit cycle.

## Configuration
- PIPE_HAZARD_CTRL_PERF_EN:
  - Defined: adds 32-bit wrapping counters as output ports `perf_stall_cnt` (cycles with `pc_we`=0 outside reset) and `perf_flush_cnt` (cycles with `id_ex_flush`=1 outside reset). Both clear on reset.
  - Undefined: the ports and logic are absent, and behaviour is otherwise identical.

## Structure
- `pipe_ctrl_pkg` holds the state encoding (RUN/LU_STALL/MEM_WAIT), the state width, and the bubble control-field constant shared with the stage registers.
- Sub-module `pipe_hazard_cmp` is the purely combinational load-use comparator (rs/rd compare with the x0 guard). It is reused by the forwarding unit.

## Test plan
- Load writing x5 in EX, ID reads x5 via rs2: cycle t gives `pc_we`=0, `if_id_we`=0, `id_ex_flush`=1. Cycle t+1 gives `state_o`=1 with all `_we`=1. Cycle t+2 is RUN.
- Load with `ex_rd`=0 and ID reads x0: no stall, all `_we`=1.
- `ex_redirect` pulse for one cycle: `if_id_flush`=`id_ex_flush`=1 and `pc_we`=1 in that cycle only.
- `dmem_busy` held 3 cycles together with `ex_redirect`: three cycles with all `_we`=0, then one cycle with both flushes=1.
- MAX_WAIT=4 and `dmem_busy` held 6 cycles: `err_timeout` rises at the end of the 4th busy cycle and stays set after busy drops. Reset clears it.
- Reset asserted during LU_STALL: next cycle `state_o`=0 and outputs show the reset pattern. After release, the same hazard is re-detected and stalls again.
